// File: rtl/demux_1xn_stream_if.sv
// Stream bundle for demux_1xn_stream.
// Carries the single input stream (valid/ready, data, select, broadcast), the
// N per-channel output streams (valid/ready, flattened data) and the drop
// status (saturating drop counter, sticky error flag).
// master: producer/consumer side (the bench). slave: the demultiplexer.
interface demux_1xn_stream_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_bcast;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [CNT_W-1:0]     drop_cnt;
    logic                 err;

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt, err
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_cnt, err
    );
endinterface

// File: rtl/demux_1xn_stream.sv
// Registered 1-to-N stream demultiplexer with a single-entry hold buffer.
// An accepted beat is held until every targeted channel has handshaked it;
// broadcast beats drain channel by channel. Beats whose select is out of
// range are consumed and dropped, bumping a saturating counter and a sticky
// error flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - stream bundle (slave side): in_valid/in_ready/in_data/in_sel/
//          in_bcast, out_valid[N]/out_ready[N]/out_data[N*WIDTH],
//          drop_cnt[CNT_W], err
module demux_1xn_stream #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    demux_1xn_stream_if.slave   bus
);

    logic [WIDTH-1:0] hold_data;
    logic [N-1:0]     hold_mask;
    logic [CNT_W-1:0] drop_cnt_q;
    logic             err_q;

    logic             in_ready_c;
    logic             in_fire;
    logic             sel_ok;
    logic [N-1:0]     sel_onehot;

    // Ready when nothing pending stays pending past this edge.
    assign in_ready_c   = ((hold_mask & ~bus.out_ready) == '0);
    assign bus.in_ready = in_ready_c;
    assign in_fire      = bus.in_valid & in_ready_c;
    assign sel_ok       = (32'(bus.in_sel) < N);

    // One-hot decode of the select; all zeros when out of range.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            sel_onehot[i] = (32'(bus.in_sel) == 32'(i));
        end
    end

    // Hold buffer, drop counter and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_mask  <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (in_fire && bus.in_bcast) begin
                hold_data <= bus.in_data;
                hold_mask <= '1;
            end else if (in_fire && sel_ok) begin
                hold_data <= bus.in_data;
                hold_mask <= sel_onehot;
            end else begin
                // Covers idle, partial drains and a drop racing a drain
                // (acceptance implies every pending bit drains here).
                hold_mask <= hold_mask & ~bus.out_ready;
                if (in_fire) begin
                    err_q <= 1'b1;
                    if (drop_cnt_q != '1) begin
                        drop_cnt_q <= drop_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign bus.out_valid = hold_mask;
    assign bus.drop_cnt  = drop_cnt_q;
    assign bus.err       = err_q;

    // Non-targeted slices read zero so stale data is never visible.
    for (genvar g = 0; g < int'(N); g++) begin : g_out
        assign bus.out_data[g*WIDTH +: WIDTH] = hold_mask[g] ? hold_data : '0;
    end

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Self-checking bench for demux_1xn_stream: a 4-channel instance driven from a
// vector table with a per-channel data scoreboard, and a 3-channel instance
// exercising out-of-range drops, counter saturation and drop/drain overlap.
module tb_demux_1xn_stream;

    logic clk;
    logic rst;

    demux_1xn_stream_if #(.WIDTH(4), .N(4), .SEL_W(2), .CNT_W(8)) a ();
    demux_1xn_stream_if #(.WIDTH(4), .N(3), .SEL_W(2), .CNT_W(8)) b ();

    demux_1xn_stream #(.WIDTH(4), .N(4), .SEL_W(2), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    demux_1xn_stream #(.WIDTH(4), .N(3), .SEL_W(2), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic       bc;
        logic [3:0] d;
        logic [3:0] ordy;
        logic       exp_rdy;
        logic [3:0] exp_ov;
    } vec_t;

    localparam int unsigned NVEC = 18;

    vec_t       vecs [NVEC];
    logic [3:0] exp_q [4][$];
    int         checks;
    int         errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle on instance A: drive, check ready, score handshakes, check outputs after the edge.
    task automatic step_a(input vec_t t, input string tag);
        logic [3:0] ed;
        @(negedge clk);
        a.in_valid  = t.v;
        a.in_sel    = t.sel;
        a.in_bcast  = t.bc;
        a.in_data   = t.d;
        a.out_ready = t.ordy;
        #1;
        chk({tag, " in_ready"}, 32'(a.in_ready), 32'(t.exp_rdy));
        for (int i = 0; i < 4; i++) begin
            if (a.out_valid[i] && a.out_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s ch%0d: got unexpected beat %0h expected none", tag, i,
                             a.out_data[i*4 +: 4]);
                end else begin
                    ed = exp_q[i].pop_front();
                    chk($sformatf("%s ch%0d data", tag, i), 32'(a.out_data[i*4 +: 4]), 32'(ed));
                end
            end
        end
        if (t.v && t.exp_rdy) begin
            for (int i = 0; i < 4; i++) begin
                if (t.bc || (32'(t.sel) == 32'(i))) exp_q[i].push_back(t.d);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, 32'(a.out_valid), 32'(t.exp_ov));
        for (int i = 0; i < 4; i++) begin
            if (!a.out_valid[i]) chk($sformatf("%s ch%0d idle zero", tag, i), 32'(a.out_data[i*4 +: 4]), 32'd0);
        end
    endtask

    initial begin
        vec_t t;
        checks = 0;
        errors = 0;

        //            v     sel   bc    d      ordy     rdy   exp_ov
        // unicast streaming
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 4'h1, 4'b1111, 1'b1, 4'b0001};
        vecs[1]  = '{1'b1, 2'd1, 1'b0, 4'h2, 4'b1111, 1'b1, 4'b0010};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 4'h3, 4'b1111, 1'b1, 4'b0100};
        vecs[3]  = '{1'b1, 2'd3, 1'b0, 4'h4, 4'b1111, 1'b1, 4'b1000};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b1111, 1'b1, 4'b0000};
        // back-pressure on channel 2, next beat waits then lands with no bubble
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 4'hA, 4'b1011, 1'b1, 4'b0100};
        vecs[6]  = '{1'b1, 2'd0, 1'b0, 4'hB, 4'b1011, 1'b0, 4'b0100};
        vecs[7]  = '{1'b1, 2'd0, 1'b0, 4'hB, 4'b1011, 1'b0, 4'b0100};
        vecs[8]  = '{1'b1, 2'd0, 1'b0, 4'hB, 4'b1011, 1'b0, 4'b0100};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 4'hB, 4'b1111, 1'b1, 4'b0001};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b1111, 1'b1, 4'b0000};
        // broadcast with partial drain (select ignored)
        vecs[11] = '{1'b1, 2'd2, 1'b1, 4'h5, 4'b0000, 1'b1, 4'b1111};
        vecs[12] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b0011, 1'b0, 4'b1100};
        vecs[13] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b1100, 1'b1, 4'b0000};
        // broadcast drained fully while the next unicast is accepted
        vecs[14] = '{1'b1, 2'd1, 1'b1, 4'h6, 4'b1111, 1'b1, 4'b1111};
        vecs[15] = '{1'b1, 2'd3, 1'b0, 4'h7, 4'b1111, 1'b1, 4'b1000};
        vecs[16] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b0111, 1'b0, 4'b1000};
        vecs[17] = '{1'b0, 2'd0, 1'b0, 4'h0, 4'b1111, 1'b1, 4'b0000};

        rst = 1'b1;
        a.in_valid = 1'b0; a.in_sel = '0; a.in_bcast = 1'b0; a.in_data = '0; a.out_ready = '0;
        b.in_valid = 1'b0; b.in_sel = '0; b.in_bcast = 1'b0; b.in_data = '0; b.out_ready = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst in_ready", 32'(a.in_ready), 32'd1);
        chk("rst out_valid", 32'(a.out_valid), 32'd0);
        chk("rst out_data", 32'(a.out_data), 32'd0);
        chk("rst drop_cnt", 32'(a.drop_cnt), 32'd0);
        chk("rst err", 32'(a.err), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(a.in_ready), 32'd1);

        for (int k = 0; k < int'(NVEC); k++) begin
            step_a(vecs[k], $sformatf("v%0d", k));
        end
        for (int i = 0; i < 4; i++) chk($sformatf("sb ch%0d empty", i), 32'(exp_q[i].size()), 32'd0);
        chk("A drop_cnt", 32'(a.drop_cnt), 32'd0);
        chk("A err", 32'(a.err), 32'd0);

        // reset mid-stream with channel 2 pending
        t = '{1'b1, 2'd2, 1'b0, 4'h9, 4'b0000, 1'b1, 4'b0100};
        step_a(t, "pre-rst");
        chk("pre-rst data", 32'(a.out_data), 32'h0900);
        @(negedge clk);
        a.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", 32'(a.out_valid), 32'd0);
        chk("midrst out_data", 32'(a.out_data), 32'd0);
        chk("midrst drop_cnt", 32'(a.drop_cnt), 32'd0);
        chk("midrst in_ready", 32'(a.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        @(negedge clk);
        rst = 1'b0;

        // N=3: drop racing a channel-1 drain
        @(negedge clk);
        b.in_valid = 1'b1; b.in_sel = 2'd1; b.in_data = 4'h3; b.out_ready = 3'b000;
        #1;
        chk("mix accept in_ready", 32'(b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mix held out_valid", 32'(b.out_valid), 32'b010);
        chk("mix held out_data", 32'(b.out_data), 32'h030);
        @(negedge clk);
        b.in_sel = 2'd3; b.in_data = 4'hF; b.out_ready = 3'b010;
        #1;
        chk("mix drop in_ready", 32'(b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("mix out_valid", 32'(b.out_valid), 32'd0);
        chk("mix out_data", 32'(b.out_data), 32'd0);
        chk("mix drop_cnt", 32'(b.drop_cnt), 32'd1);
        chk("mix err", 32'(b.err), 32'd1);
        @(negedge clk);
        b.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("B rst drop_cnt", 32'(b.drop_cnt), 32'd0);
        chk("B rst err", 32'(b.err), 32'd0);

        // N=3: 300 out-of-range beats saturate the counter
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            b.in_valid = 1'b1; b.in_sel = 2'd3; b.in_data = 4'(k); b.out_ready = 3'b111;
            @(posedge clk);
            #1;
            chk($sformatf("oor%0d out_valid", k), 32'(b.out_valid), 32'd0);
            chk($sformatf("oor%0d drop_cnt", k), 32'(b.drop_cnt), (k + 1 > 255) ? 32'd255 : 32'(k + 1));
            if (k == 0) chk("oor first err", 32'(b.err), 32'd1);
        end
        @(negedge clk);
        b.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("oor final drop_cnt", 32'(b.drop_cnt), 32'd255);
        chk("oor final err", 32'(b.err), 32'd1);
        chk("oor final in_ready", 32'(b.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1xn_stream.md
# demux_1xn_stream

Registered 1-to-N stream demultiplexer with valid/ready flow control, generalising the combinational 1x2 demux to N channels with back-pressure, broadcast and out-of-range detection. One input stream carries a data word plus a channel select. The block holds each accepted beat in a single-entry buffer until every targeted output has taken it. It sits between a producer and N independent consumers, each of which may stall on its own.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- N, 4, number of output channels (2..32)
- SEL_W, 2, select width; must satisfy 2^SEL_W ≥ N
- CNT_W, 8, width of the dropped-beat counter
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  input beat present
- IN_READY  output  1  block can accept a beat this cycle
- IN_DATA  input  WIDTH  input data word
- IN_SEL  input  SEL_W  target channel index (ignored when IN_BCAST=1)
- IN_BCAST  input  1  deliver the beat to all N channels
- OUT_VALID  output  N  per-channel valid; bit i belongs to channel i
- OUT_READY  input  N  per-channel ready
- OUT_DATA  output  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- DROP_CNT  output  CNT_W  count of dropped beats, saturating
- ERR  output  1  sticky flag: at least one beat has been dropped

## Operation
- State consists of HOLD_DATA[WIDTH] and HOLD_MASK[N]. The entry is occupied when HOLD_MASK≠0.
- OUT_VALID = HOLD_MASK.
- OUT_DATA slice i = HOLD_DATA when HOLD_MASK[i]=1, else all zeros. Unselected outputs never show stale data.
- A channel handshake occurs when OUT_VALID[i] & OUT_READY[i] are both high. That bit of HOLD_MASK clears at the clock edge.
- IN_READY = ((HOLD_MASK & ~OUT_READY) == 0). The block is ready when empty, or when every pending channel drains this cycle. This is a combinational path from OUT_READY to IN_READY.
- An input transfer occurs when IN_VALID & IN_READY are both high. The transfer is classified as follows:
  - Unicast (IN_BCAST=0, IN_SEL<N): HOLD_DATA←IN_DATA and HOLD_MASK←one-hot(IN_SEL).
  - Broadcast (IN_BCAST=1): HOLD_DATA←IN_DATA and HOLD_MASK←all ones. IN_SEL is ignored.
  - Out of range (IN_BCAST=0, IN_SEL≥N): the beat is consumed and discarded; HOLD_* are not loaded. DROP_CNT increments and saturates at 2^CNT_W−1. ERR←1.
- When a drain and an accept happen in the same cycle, the new mask replaces the old one. There is no bubble.
- When a drain and a dropped beat happen in the same cycle, HOLD_MASK ends at 0.
- A broadcast entry drains partially: each channel clears independently. IN_READY stays low until the last pending channel completes.
- ERR and DROP_CNT clear only on reset.
- IN_DATA and IN_SEL are don't-care while IN_VALID=0. No state changes occur without a transfer or handshake.

## Timing
- Reset values: HOLD_MASK=0, HOLD_DATA=0, OUT_VALID=0, OUT_DATA=0, DROP_CNT=0, ERR=0. Because the block resets empty, IN_READY=1 while RST is high and immediately after it deasserts.
- Reset asserted mid-operation discards the held beat immediately, asynchronously, with no handshake.
- Latency is 1 cycle: a beat accepted at edge k appears on OUT_VALID/OUT_DATA after edge k.
- Throughput is 1 beat/cycle when the targeted consumers keep OUT_READY high.
- Outputs OUT_VALID, OUT_DATA, DROP_CNT and ERR are functions of registers only.
- IN_READY is the only combinational output.
- The input interface follows AXI-stream rules. The block never withdraws OUT_VALID[i] before its handshake. The producer must hold IN_DATA/IN_SEL/IN_BCAST stable while IN_VALID=1 and IN_READY=0.

## Test plan
- Reset/idle: assert RST mid-stream while HOLD_MASK=4'b0100 → OUT_VALID=0, OUT_DATA=0 and DROP_CNT=0 at once; IN_READY=1.
- Unicast streaming: N=4, all OUT_READY=1, send IN_DATA=1,2,3,4 with IN_SEL=0,1,2,3 back-to-back → each value appears on its channel one cycle after acceptance; IN_READY stays 1; every other slice reads 0.
- Back-pressure: IN_SEL=2, IN_DATA=4'hA, OUT_READY[2]=0 for 3 cycles → OUT_VALID=4'b0100 held with data stable and IN_READY=0; raising OUT_READY[2] gives a handshake and a second beat is accepted in the same cycle.
- Broadcast partial drain: IN_BCAST=1, IN_DATA=4'h5, OUT_READY=4'b0011, then 4'b1100 the next cycle → HOLD_MASK goes 1111→1100→0000; IN_READY=0 until the second cycle, then 1.
- Out of range: N=3, SEL_W=2, IN_SEL=3 for 300 beats → no OUT_VALID activity; ERR=1 after the first beat; DROP_CNT saturates at 255.
- Mixed drop and drain in the same cycle: channel 1 is draining while a beat with IN_SEL=3 (N=3) is accepted → HOLD_MASK=0 and DROP_CNT increments by 1.
